matrix_sum_stream_serializer: RTL and testbench

- Downstream stage of the matrix-add AXI-Stream wrapper.
- Accepts one wide result vector per transfer (120 elements × 17 bits = 2040 bits, S0V0 in the MSBs).
- Emits the vector as a packet of fixed-width beats on a narrow stream, so results can reach a DMA/FIFO datapath.
- Marks the final beat of each packet with m_last.

---
 rtl/matrix_sum_stream_serializer.sv | 135 +++++++++++++
 tb/tb_matrix_sum_stream_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_sum_stream_serializer.sv
// Serializes one wide matrix-sum result vector into a packet of narrow beats, MSB chunk first.
// Define MATRIX_SUM_SERIALIZER_PREFETCH_EN to add a one-entry holding buffer for gapless packets.
module matrix_sum_stream_serializer #(
  parameter int IN_WIDTH   = 2040,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [BEAT_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int NUM_BEATS = (IN_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int PAD_WIDTH = NUM_BEATS * BEAT_WIDTH - IN_WIDTH;
  localparam int BUF_W     = NUM_BEATS * BEAT_WIDTH;
  localparam int CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BEATS - 1);
  localparam logic FIRST_IS_LAST = (NUM_BEATS == 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BUF_W-1:0]      r_shift;  // beats still to be presented after the current one
  logic [BEAT_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_s_ready;

  logic [BUF_W-1:0] w_padded;
  logic [BUF_W-1:0] w_src;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_at_last;

  assign w_padded   = BUF_W'(s_data) << PAD_WIDTH;
  assign w_in_xfer  = s_valid & r_s_ready & enable;
  assign w_out_xfer = r_m_valid & m_ready & enable;
  assign w_at_last  = (r_cnt == LAST_CNT);
  assign w_cnt_inc  = r_cnt + 1'b1;

`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
  logic [BUF_W-1:0] r_hold;
  logic             r_full;
  // A buffered vector has priority over one arriving on the same edge (which cannot happen while full).
  assign w_src = r_full ? r_hold : w_padded;
`else
  assign w_src = w_padded;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_s_ready <= 1'b1;
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
      r_hold    <= '0;
      r_full    <= 1'b0;
`endif
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_shift   <= w_padded << BEAT_WIDTH;
            r_m_data  <= w_padded[BUF_W-1 -: BEAT_WIDTH];
            r_cnt     <= '0;
            r_m_valid <= 1'b1;
            r_m_last  <= FIRST_IS_LAST;
            r_state   <= SEND;
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
            r_s_ready <= 1'b1;
`else
            r_s_ready <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (w_out_xfer && !w_at_last) begin
            r_cnt    <= w_cnt_inc;
            r_m_data <= r_shift[BUF_W-1 -: BEAT_WIDTH];
            r_shift  <= r_shift << BEAT_WIDTH;
            r_m_last <= (w_cnt_inc == LAST_CNT);
          end else if (w_out_xfer) begin
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
            if (r_full || w_in_xfer) begin
              // Next vector follows the last beat with no bubble.
              r_shift   <= w_src << BEAT_WIDTH;
              r_m_data  <= w_src[BUF_W-1 -: BEAT_WIDTH];
              r_cnt     <= '0;
              r_m_last  <= FIRST_IS_LAST;
              r_full    <= 1'b0;
              r_s_ready <= 1'b1;
            end else begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_cnt     <= '0;
              r_s_ready <= 1'b1;
              r_state   <= IDLE;
            end
`else
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
            r_state   <= IDLE;
`endif
          end
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
          if (w_in_xfer && !(w_out_xfer && w_at_last)) begin
            r_hold    <= w_padded;
            r_full    <= 1'b1;
            r_s_ready <= 1'b0;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
endmodule

// File: tb/tb_matrix_sum_stream_serializer.sv
// Directed bench for matrix_sum_stream_serializer: table of vectors plus stall, reset and back-to-back sequences.
module tb_matrix_sum_stream_serializer;
  localparam int IW = 2040;
  localparam int BW = 64;
  localparam int NB = 32;
  localparam int PW = NB * BW - IW;

  logic          clk = 1'b0;
  logic          reset, enable, s_valid, s_ready, m_valid, m_last, m_ready;
  logic [IW-1:0] s_data;
  logic [BW-1:0] m_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [BW-1:0] cap_data [NB];
  logic          cap_last [NB];

  matrix_sum_stream_serializer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] d;
    int            beat;
    logic [BW-1:0] exp;
    logic          exp_last;
    int            stall_beat;
    int            stall_len;
    int            stall_kind;  // 0: m_ready low, 1: enable low
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat_of(input logic [IW-1:0] d, input int k);
    logic [NB*BW-1:0] p;
    p = {d, {PW{1'b0}}};
    return p[NB*BW-1-k*BW -: BW];
  endfunction

  task automatic send_vec(input logic [IW-1:0] d);
    int t;
    t = 0;
    while (!s_ready && t < 100) begin
      tick();
      t++;
    end
    chk("send_ready", BW'(s_ready), 1);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("lat_mvalid", BW'(m_valid), 1);
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
    chk("lat_sready", BW'(s_ready), 1);
`else
    chk("lat_sready", BW'(s_ready), 0);
`endif
  endtask

  task automatic recv_pkt(input logic [IW-1:0] d, input int sb, input int sl, input int kind);
    int n, t, bubbles;
    logic [BW-1:0] sd;
    logic sv, slast;
    n = 0; t = 0; bubbles = 0;
    m_ready = 1'b1;
    while (n < NB && t < 400) begin
      if (m_valid) begin
        if (n == sb) begin
          sd = m_data; sv = m_valid; slast = m_last;
          if (kind == 0) m_ready = 1'b0;
          else enable = 1'b0;
          repeat (sl) begin
            tick();
            chk("stall_data", m_data, sd);
            chk("stall_valid", BW'(m_valid), BW'(sv));
            chk("stall_last", BW'(m_last), BW'(slast));
          end
          m_ready = 1'b1;
          enable  = 1'b1;
        end
        cap_data[n] = m_data;
        cap_last[n] = m_last;
        chk($sformatf("beat%0d", n), m_data, beat_of(d, n));
        chk($sformatf("last%0d", n), BW'(m_last), BW'(n == NB - 1));
        n++;
      end else if (n > 0) begin
        bubbles++;
      end
      tick();
      t++;
    end
    chk("nbeats", BW'(n), BW'(NB));
    chk("no_bubble", BW'(bubbles), 0);
    chk("end_mvalid", BW'(m_valid), 0);
    chk("end_mlast", BW'(m_last), 0);
    chk("end_sready", BW'(s_ready), 1);
  endtask

  initial begin
    logic [IW-1:0] ones, ord, lsb1, msb1;
    vec_t tbl [7];
    int beats, nacc, t1, t2, t, n;
    logic acc;

    ones = '1;
    ord  = '0;
    for (int i = 0; i < 120; i++) ord[IW-1-17*i -: 17] = 17'(i + 1);
    lsb1 = '0; lsb1[0] = 1'b1;
    msb1 = '0; msb1[IW-1] = 1'b1;

    tbl[0] = '{ones, 0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 0, 0};
    tbl[1] = '{ones, 31, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, -1, 0, 0};
    tbl[2] = '{ord,  0,  64'h0000_8000_8000_6000, 1'b0, 5,  3, 0};
    tbl[3] = '{ord,  31, 64'hA801_D800_EE00_7800, 1'b1, 12, 4, 1};
    tbl[4] = '{lsb1, 31, 64'h0000_0000_0000_0100, 1'b1, -1, 0, 0};
    tbl[5] = '{msb1, 0,  64'h8000_0000_0000_0000, 1'b0, -1, 0, 0};
    tbl[6] = '{'0,   15, 64'h0,                   1'b0, 20, 2, 0};

    reset = 1'b1; enable = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) tick();
    chk("rst_mvalid", BW'(m_valid), 0);
    chk("rst_mlast", BW'(m_last), 0);
    chk("rst_sready", BW'(s_ready), 1);
    chk("rst_mdata", m_data, 0);
    reset = 1'b0;
    tick();

    // enable low in IDLE: an offered vector must not be taken
    enable = 1'b0; s_valid = 1'b1; s_data = ones;
    repeat (2) tick();
    chk("en0_mvalid", BW'(m_valid), 0);
    chk("en0_sready", BW'(s_ready), 1);
    s_valid = 1'b0; enable = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      send_vec(tbl[v].d);
      recv_pkt(tbl[v].d, tbl[v].stall_beat, tbl[v].stall_len, tbl[v].stall_kind);
      chk($sformatf("tbl%0d_data", v), cap_data[tbl[v].beat], tbl[v].exp);
      chk($sformatf("tbl%0d_last", v), BW'(cap_last[tbl[v].beat]), BW'(tbl[v].exp_last));
      chk($sformatf("tbl%0d_pad", v), BW'(cap_data[NB-1][7:0]), 0);
      repeat (2) tick();
    end

    // reset while beat 10 is presented
    send_vec(ones);
    m_ready = 1'b1;
    n = 0; t = 0;
    while (n < 10 && t < 100) begin
      if (m_valid) n++;
      tick();
      t++;
    end
    chk("rst10_reached", BW'(n), 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst10_mvalid", BW'(m_valid), 0);
    chk("rst10_mlast", BW'(m_last), 0);
    chk("rst10_sready", BW'(s_ready), 1);
    chk("rst10_mdata", m_data, 0);
    tick();

    // two vectors back to back with s_valid held high
    m_ready = 1'b1;
    s_data = ord; s_valid = 1'b1;
    beats = 0; nacc = 0; t1 = 0; t2 = 0; t = 0;
    while (beats < 2 * NB && t < 200) begin
      acc = s_valid & s_ready & enable;
      if (m_valid) begin
        chk($sformatf("b2b_beat%0d", beats), m_data,
            beat_of((beats < NB) ? ord : ones, beats % NB));
        chk($sformatf("b2b_last%0d", beats), BW'(m_last), BW'((beats % NB) == NB - 1));
        beats++;
        if (beats == 1) t1 = cyc;
        if (beats == NB + 1) t2 = cyc;
      end
      tick();
      t++;
      if (acc) begin
        nacc++;
        if (nacc == 1) s_data = ones;
        else begin
          s_valid = 1'b0;
          chk("b2b_sready_low", BW'(s_ready), 0);
        end
      end
    end
    s_valid = 1'b0;
    chk("b2b_nbeats", BW'(beats), BW'(2 * NB));
    chk("b2b_nacc", BW'(nacc), 2);
`ifdef MATRIX_SUM_SERIALIZER_PREFETCH_EN
    chk("b2b_gap", BW'(t2 - t1), 32);
`else
    chk("b2b_gap", BW'(t2 - t1), 33);
`endif
    chk("b2b_end_mvalid", BW'(m_valid), 0);
    chk("b2b_end_sready", BW'(s_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
